// File: rtl/pdm_mod_pkg.sv
// Shared constants and the saturating clamp for the 2nd-order PCM-to-PDM modulator.
// The LFSR constants are only used when PDM_MOD_DITHER_EN is defined.
package pdm_mod_pkg;

    localparam int PCM_W = 16;
    localparam int FS    = 32768;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci feedback taps 16,14,13,11 as a bit mask over lfsr[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Clamp v to [-2^(acc_w-2), 2^(acc_w-2)-1]
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int acc_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (acc_w - 2)) - 64'sd1;
        lo = -(64'sd1 <<< (acc_w - 2));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/pdm_sd2_core.sv
// Two saturating integrators and a 1-bit quantiser: the 2nd-order delta-sigma loop.
// PDM_MOD_DITHER_EN adds a -4..+3 LFSR dither to the loop input.
module pdm_sd2_core
    import pdm_mod_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [PCM_W-1:0] sample,
    output logic                    pdm_out
);

    // Two guard bits so the three-term sums never wrap before the clamp
    localparam int SW = ACC_W + 2;
    localparam logic signed [SW-1:0] FB_POS = SW'(FS);

    logic signed [ACC_W-1:0] acc1;
    logic signed [ACC_W-1:0] acc2;
    logic signed [SW-1:0]    x_w;
    logic signed [SW-1:0]    fb_w;
    logic signed [SW-1:0]    s1;
    logic signed [SW-1:0]    s2;
    logic                    y;

`ifdef PDM_MOD_DITHER_EN
    logic [15:0]          lfsr;
    logic signed [SW-1:0] dith;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end

    assign dith = SW'({1'b0, lfsr[2:0]}) - SW'(4);
`endif

    always_comb begin
        y    = ~acc2[ACC_W-1];
        x_w  = {{(SW-PCM_W){sample[PCM_W-1]}}, sample};
`ifdef PDM_MOD_DITHER_EN
        x_w  = x_w + dith;
`endif
        fb_w = y ? FB_POS : -FB_POS;
        s1   = {{2{acc1[ACC_W-1]}}, acc1} + x_w - fb_w;
        s2   = {{2{acc2[ACC_W-1]}}, acc2} + {{2{acc1[ACC_W-1]}}, acc1} - fb_w;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc1    <= '0;
            acc2    <= '0;
            pdm_out <= 1'b0;
        end else begin
            acc1    <= ACC_W'(sat(64'(s1), ACC_W));
            acc2    <= ACC_W'(sat(64'(s2), ACC_W));
            pdm_out <= y;
        end
    end

endmodule

// File: rtl/pdm_sd2_modulator.sv
// PCM-to-PDM transmitter: one-entry input buffer, INTERP-clock zero-order hold, 2nd-order loop.
// Define PDM_MOD_DITHER_EN to enable LFSR dither inside the loop.
module pdm_sd2_modulator
    import pdm_mod_pkg::*;
#(
    parameter int INTERP = 64,
    parameter int ACC_W  = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [PCM_W-1:0] pcm_in,
    input  logic                    pcm_valid,
    output logic                    pcm_ready,
    output logic                    pdm_out,
    output logic                    underrun
);

    localparam int PH_W = $clog2(INTERP);

    logic [PH_W-1:0]         phase;
    logic                    buf_full;
    logic signed [PCM_W-1:0] buf_q;
    logic signed [PCM_W-1:0] cur_sample;
    logic                    boundary;
    logic                    xfer;

    // Handshake: a sample moves when pcm_valid && pcm_ready on a rising edge; the source
    // holds pcm_in stable until then, and pcm_ready depends only on buffer occupancy.
    assign pcm_ready = !buf_full;
    assign xfer      = pcm_valid && pcm_ready;
    assign boundary  = (phase == PH_W'(INTERP - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase      <= '0;
            buf_full   <= 1'b0;
            buf_q      <= '0;
            cur_sample <= '0;
            underrun   <= 1'b0;
        end else begin
            phase    <= phase + PH_W'(1);
            underrun <= 1'b0;
            if (boundary) begin
                if (buf_full) begin
                    cur_sample <= buf_q;
                    buf_full   <= 1'b0;
                end else begin
                    underrun <= 1'b1;
                end
            end
            // A transfer on an empty-buffer boundary lands in the buffer, not cur_sample
            if (xfer) begin
                buf_q    <= pcm_in;
                buf_full <= 1'b1;
            end
        end
    end

    pdm_sd2_core #(
        .ACC_W (ACC_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .sample  (cur_sample),
        .pdm_out (pdm_out)
    );

endmodule

// File: tb/tb_pdm_sd2_modulator.sv
// Directed and random stimulus for pdm_sd2_modulator against an integer reference model.
module tb_pdm_sd2_modulator;

    localparam int INTERP = 64;
    localparam int ACC_W  = 24;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [15:0] pcm_in = '0;
    logic               pcm_valid = 1'b0;
    logic               pcm_ready;
    logic               pdm_out;
    logic               underrun;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [15:0] exp_q[$];
    longint      m_acc1;
    longint      m_acc2;
    longint      m_cur;
    int          m_phase;
    logic        m_pdm;
    logic        m_und;
    logic [15:0] m_lfsr;
    logic        last_xfer;
    int          ones;
    int          xfers;
    int          unds;

    // Clock
    always #5 clk = ~clk;

    pdm_sd2_modulator #(
        .INTERP (INTERP),
        .ACC_W  (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pcm_in    (pcm_in),
        .pcm_valid (pcm_valid),
        .pcm_ready (pcm_ready),
        .pdm_out   (pdm_out),
        .underrun  (underrun)
    );

    function automatic longint clampv(input longint v);
        longint lim;
        lim = longint'(1) <<< (ACC_W - 2);
        if (v > lim - 1) return lim - 1;
        if (v < -lim) return -lim;
        return v;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_assert++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_acc1    = 0;
        m_acc2    = 0;
        m_cur     = 0;
        m_phase   = 0;
        m_pdm     = 1'b0;
        m_und     = 1'b0;
        m_lfsr    = 16'hACE1;
        last_xfer = 1'b0;
    endtask

    // One clock: check ready, step the model, advance, check outputs
    task automatic cycle();
        logic               empty;
        logic               bnd;
        logic               y;
        longint             x;
        longint             fb;
        longint             n1;
        longint             n2;
        logic signed [15:0] popped;
        empty = (exp_q.size() == 0);
        check_bit("pcm_ready", pcm_ready, empty);
        last_xfer = pcm_valid && empty;
        bnd = (m_phase == INTERP - 1);
        y   = (m_acc2 >= 0);
        fb  = y ? 64'sd32768 : -64'sd32768;
        x   = m_cur;
`ifdef PDM_MOD_DITHER_EN
        x = x + longint'(m_lfsr[2:0]) - 4;
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
        n1 = clampv(m_acc1 + x - fb);
        n2 = clampv(m_acc2 + m_acc1 - fb);
        m_acc1 = n1;
        m_acc2 = n2;
        m_pdm  = y;
        m_und  = bnd && empty;
        if (bnd && !empty) begin
            popped = exp_q.pop_front();
            m_cur  = popped;
        end
        if (last_xfer) begin
            exp_q.push_back(pcm_in);
            xfers++;
        end
        m_phase = (m_phase + 1) % INTERP;
        @(posedge clk);
        #1;
        check_bit("pdm_out", pdm_out, m_pdm);
        check_bit("underrun", underrun, m_und);
        ones += int'(pdm_out);
        unds += int'(underrun);
    endtask

    // Hold valid high with a constant sample, settle, then count ones over a window
    task automatic stream(input string tag, input logic signed [15:0] val, input int settle,
                          input int window, input int lo, input int hi);
        pcm_valid = 1'b1;
        pcm_in    = val;
        for (int i = 0; i < settle; i++) cycle();
        ones = 0;
        for (int i = 0; i < window; i++) cycle();
        check_range(tag, ones, lo, hi);
    endtask

    // Asynchronous reset asserted between clock edges
    task automatic mid_clock_reset();
        #3;
        rst = 1'b1;
        #1;
        check_bit("rst_pdm_out", pdm_out, 1'b0);
        check_bit("rst_pcm_ready", pcm_ready, 1'b1);
        check_bit("rst_underrun", underrun, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        ones  = 0;
        xfers = 0;
        unds  = 0;

        // Power-on reset applied while clk is low
        #2;
        rst = 1'b1;
        #1;
        check_bit("por_pdm_out", pdm_out, 1'b0);
        check_bit("por_pcm_ready", pcm_ready, 1'b1);
        check_bit("por_underrun", underrun, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Density at mid, +half and -half scale
        stream("dens_zero", 16'sd0, 128, 1024, 510, 514);
        stream("dens_pos_half", 16'sd16384, 192, 1024, 764, 772);
        stream("dens_neg_half", -16'sd16384, 192, 1024, 252, 260);

        // Random samples with random valid gaps; source holds data until accepted
        pcm_valid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!pcm_valid || last_xfer) begin
                pcm_valid = ($urandom_range(0, 3) != 0);
                pcm_in    = 16'($urandom_range(0, 65535));
            end
            cycle();
        end

        // Continuous valid: one transfer per frame in steady state
        pcm_valid = 1'b1;
        pcm_in    = 16'sd1000;
        for (int i = 0; i < 200; i++) cycle();
        xfers = 0;
        for (int i = 0; i < 640; i++) cycle();
        check_range("xfer_per_frame", xfers, 10, 10);

        // Starved source: underrun every boundary, held sample keeps its density
        pcm_valid = 1'b0;
        for (int i = 0; i < 128; i++) cycle();
        unds = 0;
        ones = 0;
        xfers = 0;
        for (int i = 0; i < 1024; i++) cycle();
        check_range("underrun_per_frame", unds, 16, 16);
        check_range("no_xfer_when_idle", xfers, 0, 0);
        check_range("dens_held", ones, 523, 532);

        // Reset mid-frame with the buffer full
        pcm_valid = 1'b1;
        pcm_in    = 16'sd5000;
        for (int i = 0; i < 37; i++) cycle();
        mid_clock_reset();
        pcm_valid = 1'b0;
        for (int i = 0; i < 70; i++) cycle();

        // Full-scale extremes
        stream("dens_pos_full", 16'sd32767, 3072, 1024, 1018, 1024);
        stream("dens_neg_full", -16'sd32768, 192, 1024, 0, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
